// File: rtl/majority_pkg.sv
// Shared definitions for the majority arbiter: FSM encoding, default sizes and
// the majority threshold helper.
package majority_pkg;

  localparam int MAJ_W    = 7;
  localparam int MAJ_NREQ = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EVAL  = 2'd2;

  function automatic int maj_threshold(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/majority_arbiter_if.sv
// Requester-side bundle of the majority arbiter: level requests, packed vote
// words, grant pulses and the registered result strobe.
interface majority_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 7
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(W + 1);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               done_vld;
  logic [ID_W-1:0]    done_id;
  logic               done_maj;
  logic [CNT_W-1:0]   done_cnt;

  modport master (
    output req, data,
    input  gnt, busy, done_vld, done_id, done_maj, done_cnt
  );

  modport slave (
    input  req, data,
    output gnt, busy, done_vld, done_id, done_maj, done_cnt
  );
endinterface

// File: rtl/majority_core.sv
// Combinational majority evaluator: popcount of the vote word and a compare
// against the (W+1)/2 threshold.
module majority_core
  import majority_pkg::*;
#(
  parameter int W = MAJ_W
) (
  input  logic [W-1:0]             in,
  output logic [$clog2(W+1)-1:0]   cnt,
  output logic                     maj
);
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] THR = CNT_W'(maj_threshold(W));

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CNT_W'(in[i]);
    end
    maj = (cnt >= THR);
  end
endmodule

// File: rtl/majority_arbiter.sv
// Round-robin scheduler sharing one majority_core among N_REQ requesters; one
// transaction every three cycles (IDLE -> GRANT -> EVAL).
module majority_arbiter
  import majority_pkg::*;
#(
  parameter int N_REQ = MAJ_NREQ,
  parameter int W     = MAJ_W
) (
  input logic               clk,
  input logic               rst,
  majority_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(W + 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [W-1:0]     opnd;

  logic             any;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  cand;
  logic [W-1:0]     wdata;
  logic [CNT_W-1:0] core_cnt;
  logic             core_maj;

  // Search starts one past the last served requester so every waiter is
  // reached within N_REQ transactions.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!any && bus.req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) wdata = bus.data[k*W +: W];
    end
  end

  majority_core #(.W(W)) u_core (
    .in  (opnd),
    .cnt (core_cnt),
    .maj (core_maj)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      opnd         <= '0;
      bus.gnt      <= '0;
      bus.busy     <= 1'b0;
      bus.done_vld <= 1'b0;
      bus.done_id  <= '0;
      bus.done_maj <= 1'b0;
      bus.done_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done_vld <= 1'b0;
          if (any) begin
            state    <= GRANT;
            opnd     <= wdata;
            id_q     <= win;
            bus.gnt  <= N_REQ'(1) << win;
            bus.busy <= 1'b1;
          end
        end
        GRANT: begin
          state        <= EVAL;
          bus.gnt      <= '0;
          bus.done_vld <= 1'b1;
          bus.done_id  <= id_q;
          bus.done_maj <= core_maj;
          bus.done_cnt <= core_cnt;
        end
        EVAL: begin
          state        <= IDLE;
          bus.done_vld <= 1'b0;
          bus.busy     <= 1'b0;
          ptr          <= id_q;
        end
        default: begin
          state        <= IDLE;
          bus.gnt      <= '0;
          bus.done_vld <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_majority_arbiter.sv
// Directed bench for majority_arbiter: transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_majority_arbiter;
  localparam int NR = 4;
  localparam int WW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  majority_arbiter_if #(.N_REQ(NR), .W(WW)) bus ();

  majority_arbiter #(.N_REQ(NR), .W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  bit auto_drop = 1'b0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks whole transactions (who was served last, which word
  // is in flight, how far along it is) and derives outputs from them.
  logic [NR-1:0] m_gnt;
  logic          m_busy, m_vld, m_maj;
  int            m_id, m_cnt, m_phase, m_last, m_cur;
  logic [WW-1:0] m_word;
  bit            m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_gnt = '0; m_busy = 0; m_vld = 0; m_maj = 0;
      m_id = 0; m_cnt = 0; m_phase = 0; m_last = NR - 1; m_cur = 0;
      m_on = 1'b1;
    end else if (m_phase == 0) begin
      int pick;
      m_vld = 0;
      pick = -1;
      for (int s = 1; s <= NR; s++) begin
        int k;
        k = (m_last + s) % NR;
        if (pick < 0 && bus.req[k]) pick = k;
      end
      if (pick >= 0) begin
        m_cur   = pick;
        m_word  = bus.data[pick*WW +: WW];
        m_gnt   = NR'(1) << pick;
        m_busy  = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_gnt   = '0;
      m_vld   = 1;
      m_id    = m_cur;
      m_cnt   = $countones(m_word);
      m_maj   = (2 * m_cnt > WW);
      m_phase = 2;
    end else begin
      m_vld   = 0;
      m_busy  = 0;
      m_last  = m_cur;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_gnt",  32'(bus.gnt),      32'(m_gnt));
      chk("m_busy", 32'(bus.busy),     32'(m_busy));
      chk("m_vld",  32'(bus.done_vld), 32'(m_vld));
      chk("m_id",   32'(bus.done_id),  32'(m_id));
      chk("m_cnt",  32'(bus.done_cnt), 32'(m_cnt));
      chk("m_maj",  32'(bus.done_maj), 32'(m_maj));
    end
  end

  // Advance to the next falling edge; a requester that sees its own result
  // drops its request here, i.e. before the edge that ends done_vld.
  task automatic cyc();
    @(negedge clk);
    if (auto_drop && bus.done_vld === 1'b1) bus.req[bus.done_id] = 1'b0;
  endtask

  task automatic set_word(input int k, input logic [WW-1:0] v);
    bus.data[k*WW +: WW] = v;
  endtask

  task automatic wait_done(input string name, output int id, output int cnt, output int maj);
    bit got;
    got = 0; id = -1; cnt = -1; maj = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if (bus.done_vld === 1'b1) begin
        got = 1; id = bus.done_id; cnt = bus.done_cnt; maj = bus.done_maj;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no done_vld within 12 cycles, required one", name);
    end
  endtask

  task automatic wait_gnt(input string name, output int t, output int g);
    bit got;
    got = 0; t = -1; g = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if (bus.gnt !== '0) begin
        got = 1; t = cyc_n; g = bus.gnt;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no gnt within 12 cycles, required one", name);
    end
  endtask

  int id, cnt, maj, t, g, t_prev;
  int exp_cnt [4] = '{6, 4, 1, 2};
  int exp_maj [4] = '{1, 1, 0, 0};

  initial begin
    bus.req  = '0;
    bus.data = '0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_gnt",  32'(bus.gnt),      0);
    chk("rst_busy", 32'(bus.busy),     0);
    chk("rst_vld",  32'(bus.done_vld), 0);
    chk("rst_cnt",  32'(bus.done_cnt), 0);
    rst = 1'b0;
    auto_drop = 1'b1;

    // Single requester, word 1100011
    set_word(0, 7'd99);
    bus.req = 4'b0001;
    cyc();
    chk("single_gnt",  32'(bus.gnt),  4'b0001);
    chk("single_busy", 32'(bus.busy), 1);
    wait_done("single_done", id, cnt, maj);
    chk("single_id",  id,  0);
    chk("single_cnt", cnt, 4);
    chk("single_maj", maj, 1);
    cyc();
    chk("single_idle_busy", 32'(bus.busy), 0);

    // Below threshold, word 0011100
    set_word(1, 7'd28);
    bus.req = 4'b0010;
    wait_done("below_done", id, cnt, maj);
    chk("below_id",  id,  1);
    chk("below_cnt", cnt, 3);
    chk("below_maj", maj, 0);
    cyc();

    // Fresh pointer so requester 0 wins first
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All four requesting at once
    set_word(0, 7'd119); set_word(1, 7'd101); set_word(2, 7'd32); set_word(3, 7'd48);
    bus.req = 4'b1111;
    t_prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("all_gnt_wait", t, g);
      chk($sformatf("all_gnt%0d", k), g, 32'(1) << k);
      if (k > 0) chk($sformatf("all_spacing%0d", k), t - t_prev, 3);
      t_prev = t;
      wait_done("all_done", id, cnt, maj);
      chk($sformatf("all_id%0d", k),  id,  k);
      chk($sformatf("all_cnt%0d", k), cnt, exp_cnt[k]);
      chk($sformatf("all_maj%0d", k), maj, exp_maj[k]);
    end

    // Fairness with two permanent requesters
    auto_drop = 1'b0;
    set_word(0, 7'd75);
    set_word(2, 7'd127);
    bus.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_done("fair_done", id, cnt, maj);
      chk($sformatf("fair_id%0d", k),  id,  (k % 2 == 0) ? 0 : 2);
      chk($sformatf("fair_cnt%0d", k), cnt, (k % 2 == 0) ? 4 : 7);
      chk($sformatf("fair_maj%0d", k), maj, 1);
    end
    bus.req = '0;
    auto_drop = 1'b1;
    cyc();

    // Data changes after it was sampled
    set_word(0, 7'd99);
    bus.req = 4'b0001;
    cyc();
    set_word(0, 7'd0);
    wait_done("late_done", id, cnt, maj);
    chk("late_cnt", cnt, 4);
    chk("late_maj", maj, 1);
    cyc();

    // Reset during the GRANT cycle of a requester-2 transaction
    set_word(2, 7'd85);
    bus.req = 4'b0100;
    cyc();
    chk("midrst_gnt2", 32'(bus.gnt), 4'b0100);
    rst = 1'b1;
    bus.req = 4'b0101;
    set_word(0, 7'd99);
    cyc();
    chk("midrst_gnt",  32'(bus.gnt),      0);
    chk("midrst_busy", 32'(bus.busy),     0);
    chk("midrst_vld",  32'(bus.done_vld), 0);
    chk("midrst_id",   32'(bus.done_id),  0);
    chk("midrst_cnt",  32'(bus.done_cnt), 0);
    chk("midrst_maj",  32'(bus.done_maj), 0);
    rst = 1'b0;
    wait_gnt("midrst_next_wait", t, g);
    chk("midrst_next_gnt", g, 4'b0001);
    wait_done("midrst_done0", id, cnt, maj);
    chk("midrst_id0",  id,  0);
    chk("midrst_cnt0", cnt, 4);
    wait_done("midrst_done2", id, cnt, maj);
    chk("midrst_id2",  id,  2);
    chk("midrst_cnt2", cnt, 4);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/majority_arbiter.md
# majority_arbiter

Round-robin scheduler that shares one 7-bit majority evaluator among several requesters. Each requester presents a vote word and a request. The block grants one requester at a time, evaluates the word through a single shared majority core, and returns the majority bit, the ones-count and the requester ID with a one-cycle done strobe. It sits between the vote sources and the majority datapath, so the design needs only one evaluator instance.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8
- W, 7: vote word width; must be odd. Majority threshold is (W+1)/2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request level
- data  in  N_REQ*W  vote words; requester k occupies bits [k*W +: W]
- gnt  out  N_REQ  one-hot grant pulse, registered
- busy  out  1  high whenever state is not IDLE
- done_vld  out  1  one-cycle result strobe
- done_id  out  $clog2(N_REQ)  ID of the requester whose result is presented
- done_maj  out  1  1 when ones-count >= (W+1)/2
- done_cnt  out  $clog2(W+1)  ones-count of the latched word

## Operation
- FSM states:
  - IDLE -> GRANT when any req bit is high.
  - GRANT -> EVAL, unconditional.
  - EVAL -> IDLE, unconditional.
- Arbitration happens in IDLE:
  - Winner is the first asserted req searching upward (mod N_REQ) from ptr+1.
  - On the leaving edge, the winner's data word is latched into opnd and its index into id_q.
- GRANT:
  - gnt[id_q] is high for exactly this cycle.
  - The majority core output, computed from opnd, is registered into done_maj/done_cnt/done_id on the leaving edge.
- EVAL:
  - done_vld = 1 for this cycle.
  - On the leaving edge, ptr <= id_q.
- Requester protocol:
  - Hold req high and data stable from assertion until done_vld with a matching done_id.
  - Drop req on the edge that ends the done_vld cycle. A req still high in the following IDLE cycle is a new request.
- Data is sampled only at the IDLE->GRANT edge. Changes to data afterwards do not affect the in-flight result.
- Requests arriving while busy wait. None are lost, since req is level.
- Reset values:
  - state = IDLE, ptr = N_REQ-1 (requester 0 wins first), opnd = 0, id_q = 0.
  - gnt = 0, done_vld = 0, done_id = 0, done_maj = 0, done_cnt = 0, busy = 0.
- Reset mid-transaction (GRANT or EVAL):
  - The transaction is dropped with no done_vld.
  - ptr returns to N_REQ-1.
- done_id/done_maj/done_cnt hold their last value between strobes. They are qualified only by done_vld.

## Timing
- Cycle t: IDLE with req sampled.
- Cycle t+1: gnt pulse, busy=1.
- Cycle t+2: done_vld with valid result.
- Cycle t+3: IDLE; earliest next arbitration.
- Throughput is one transaction per 3 cycles. Back-to-back requesters see grants spaced exactly 3 cycles apart.
- All outputs are registered. There is no combinational path from req/data to any output.
- done_cnt range is 0..W. Its width is $clog2(W+1), which is 3 for W=7.

## Structure
- Shared package majority_pkg holds:
  - the state encoding constants (IDLE, GRANT, EVAL, 2-bit);
  - defaults MAJ_W=7 and MAJ_NREQ=4.
- Sub-module majority_core (combinational, parameter W):
  - input vector in[W-1:0];
  - outputs cnt ($clog2(W+1)) and maj;
  - popcount plus threshold compare.
- The top level instantiates majority_core once.
- Round-robin search lives in the top level as a rotate/priority-encode loop.

## Test plan
- Single requester: rst for 2 cycles, then req=0001 with data0=99 (1100011). Required: gnt=0001 at t+1; done_vld at t+2 with id 0, cnt=4, maj=1; busy low at t+3.
- Below threshold: req1 only, data1=28 (0011100). Required: done id 1, cnt=3, maj=0.
- Simultaneous requests: req=1111 with data 119, 101, 32, 48, each requester dropping req after its done. Required:
  - grants to 0, 1, 2, 3, spaced 3 cycles apart;
  - results (cnt/maj) 6/1, 4/1, 1/0, 2/0.
- Fairness: req0 and req2 held permanently, data0=75, data2=127. Required:
  - done_id alternates 0, 2, 0, 2 over 4 transactions;
  - results 4/1 for requester 0 and 7/1 for requester 2.
- Data change after sampling: data0 switches 99 -> 0 during the GRANT cycle. Required: done cnt=4, maj=1 (latched value).
- Reset mid-operation: rst asserted in the GRANT cycle of a requester-2 transaction, with req=0101 held afterwards. Required:
  - no done_vld for that transaction;
  - all outputs zero the cycle after reset;
  - next grant goes to requester 0.
